// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo slice.
// Default configuration; mode is chosen by SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_WIDTH = 4;
  localparam int DEF_DEPTH         = 16;
  localparam int DEF_AF_LEVEL      = 14;
  localparam int DEF_AE_LEVEL      = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Level must reach DEPTH, so one bit wider than the address.
  function automatic int level_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Dual-port storage for sync_fifo: synchronous write,
// asynchronous read, no reset on the array.
module sync_fifo_ram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int WORDS = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered level, status and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AF_LEVEL      = DEF_AF_LEVEL,
  parameter int AE_LEVEL      = DEF_AE_LEVEL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   err_clr,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDRESS_WIDTH:0] fill_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int LW = level_width(ADDRESS_WIDTH);
  typedef logic [LW-1:0] lvl_t;
  typedef logic [ADDRESS_WIDTH:0] ptr_t;

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  ptr_t rd_ptr_nxt;
  lvl_t level;
  lvl_t level_nxt;
  logic wr_ok;
  logic rd_ok;
  op_e  op;
  logic [ADDRESS_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0]    ram_q;

  assign wr_ok = wr_en & ~fifo_full;
  assign rd_ok = rd_en & ~fifo_empty;
  assign op    = op_e'({wr_ok, rd_ok});

  assign rd_ptr_nxt = rd_ptr + ptr_t'(rd_ok);

  always_comb begin
    level_nxt = level;
    unique case (op)
      OP_WR:   level_nxt = level + lvl_t'(1);
      OP_RD:   level_nxt = level - lvl_t'(1);
      default: level_nxt = level;
    endcase
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Look one word ahead so the head is ready right after a read.
  assign ram_raddr = rd_ptr_nxt[ADDRESS_WIDTH-1:0];
`else
  assign ram_raddr = rd_ptr[ADDRESS_WIDTH-1:0];
`endif

  sync_fifo_ram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDRESS_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_addr (ram_raddr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      fifo_full    <= (level_nxt == lvl_t'(DEPTH));
      fifo_empty   <= (level_nxt == '0);
      almost_full  <= (level_nxt >= lvl_t'(AF_LEVEL));
      almost_empty <= (level_nxt <= lvl_t'(AE_LEVEL));
    end
  end

  assign fill_level = level;

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && fifo_full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && fifo_empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  lvl_t level_left;
  assign level_left = level - lvl_t'(rd_ok);

  // A write into an otherwise empty FIFO bypasses the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (level_left != '0) begin
      data_out <= ram_q;
    end else if (wr_ok) begin
      data_out <= data_in;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= ram_q;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (standard or SYNC_FIFO_FWFT_EN mode).
// Queue model checked every cycle plus directed literal expectations.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] fill_level;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  sync_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: a word queue with bounded capacity.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_dout = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        automatic int  sz = q.size();
        automatic logic w_ok = wr_en && (sz < 16);
        automatic logic r_ok = rd_en && (sz > 0);
        if (wr_en && sz == 16) m_ovf = 1'b1;
        else if (err_clr) m_ovf = 1'b0;
        if (rd_en && sz == 0) m_udf = 1'b1;
        else if (err_clr) m_udf = 1'b0;
        if (r_ok) begin
          automatic logic [7:0] w = q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
          m_dout = w;
`endif
        end
        if (w_ok) q.push_back(data_in);
`ifdef SYNC_FIFO_FWFT_EN
        if (q.size() > 0) m_dout = q[0];
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("level", fill_level, q.size());
      chk("full", fifo_full, q.size() == 16);
      chk("empty", fifo_empty, q.size() == 0);
      chk("afull", almost_full, q.size() >= 14);
      chk("aempty", almost_empty, q.size() <= 2);
      chk("ovf", overflow, m_ovf);
      chk("udf", underflow, m_udf);
      chk("dout", data_out, m_dout);
    end
  end

  task automatic op(input logic w, input logic r,
                    input logic [7:0] d, input logic c);
    wr_en = w;
    rd_en = r;
    data_in = d;
    err_clr = c;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic read_expect(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd_word", data_out, exp);
    op(1'b0, 1'b1, 8'h00, 1'b0);
`else
    op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rd_word", data_out, exp);
`endif
  endtask

  initial begin
    #12;
    chk("rst_level", fill_level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_dout", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      op(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 13) chk("af_13", almost_full, 0);
      if (i == 14) chk("af_14", almost_full, 1);
      if (i == 15) chk("full_15", fifo_full, 0);
    end
    chk("full_16", fifo_full, 1);
    chk("level_16", fill_level, 16);

    op(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fill_level, 16);
    for (int i = 1; i <= 16; i++) read_expect(8'(i));
    chk("drained", fifo_empty, 1);
    op(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", overflow, 0);

    op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_set", underflow, 1);
    chk("udf_dout", data_out, 8'h10);
    chk("udf_level", fill_level, 0);
    op(1'b0, 1'b1, 8'h00, 1'b1);
    chk("set_wins", underflow, 1);
    op(1'b0, 1'b0, 8'h00, 1'b1);
    chk("udf_clr", underflow, 0);

    op(1'b1, 1'b1, 8'h50, 1'b0);
    chk("both_at0", fill_level, 1);
    for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    op(1'b1, 1'b1, 8'h55, 1'b0);
    chk("both_at5", fill_level, 5);
    for (int i = 0; i < 11; i++) op(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    chk("level_16b", fill_level, 16);
    op(1'b1, 1'b1, 8'h77, 1'b0);
    chk("both_at16", fill_level, 15);
    read_expect(8'h52);
    for (int i = 0; i < 14; i++) op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("empty_again", fifo_empty, 1);
    op(1'b0, 1'b0, 8'h00, 1'b1);

    for (int k = 0; k < 40; k++) begin
      op(1'b1, 1'b0, 8'(8'h20 + k), 1'b0);
      read_expect(8'(8'h20 + k));
    end

    for (int i = 0; i < 7; i++) op(1'b1, 1'b0, 8'(8'h61 + i), 1'b0);
    chk("level_7", fill_level, 7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", fill_level, 0);
    chk("mid_rst_empty", fifo_empty, 1);
    chk("mid_rst_aempty", almost_empty, 1);
    chk("mid_rst_dout", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b1, 1'b0, 8'h99, 1'b0);
    read_expect(8'h99);
    chk("post_rst_level", fill_level, 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
